// File: rtl/instr_selftest.sv
// Post-reset register self-test: pulses a reset to the core under test, waits
// for it to settle, then reads a fixed list of registers over the debug port
// and compares each against its expected value.
module instr_selftest #(
  parameter int                          XLEN         = 32,
  parameter int                          REG_AW       = 5,
  parameter int                          NUM_CHECKS   = 4,
  parameter int                          RST_CYCLES   = 1,
  parameter int                          WAIT_CYCLES  = 7,
  parameter logic [NUM_CHECKS*REG_AW-1:0] CHECK_ADDRS  = '0,
  parameter logic [NUM_CHECKS*XLEN-1:0]   CHECK_VALUES = '0,
  parameter bit                          STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              dut_reset,
  output logic              dbg_re,
  output logic [REG_AW-1:0] dbg_addr,
  input  logic [XLEN-1:0]   dbg_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        fail_count,
  output logic [3:0]        first_fail_idx,
  output logic [XLEN-1:0]   first_fail_data
);

  localparam int CW = 16;
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(NUM_CHECKS - 1);

  typedef enum logic [2:0] {IDLE, RST_DUT, WAIT, READ, CMP, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      idx, idx_n;
  logic            accept, mismatch;
  logic [XLEN-1:0] exp_val;

  assign accept    = start && (state == IDLE || state == DONE);
  assign exp_val   = CHECK_VALUES[idx*XLEN +: XLEN];
  assign mismatch  = (dbg_rdata != exp_val);
  assign dut_reset = (state == RST_DUT) || reset;

  // State, phase counter and check index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state: reset pulse, settle wait, then READ/CMP pairs per check
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = RST_DUT;
        cnt_n   = '0;
        idx_n   = '0;
      end
      RST_DUT: if (cnt == RST_LAST) begin
        cnt_n   = '0;
        state_n = (WAIT_CYCLES == 0) ? READ : WAIT;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      WAIT: if (cnt == WAIT_LAST) begin
        cnt_n   = '0;
        state_n = READ;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      READ: state_n = CMP;
      CMP: if (idx == IDX_LAST || (STOP_ON_FAIL && mismatch)) begin
        state_n = DONE;
      end else begin
        idx_n   = idx + 1'b1;
        state_n = READ;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs: strobes follow the next state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      dbg_re          <= 1'b0;
      dbg_addr        <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
    end else begin
      busy     <= (state_n == RST_DUT) || (state_n == WAIT) ||
                  (state_n == READ)    || (state_n == CMP);
      dbg_re   <= (state_n == READ);
      dbg_addr <= (state_n == READ) ? CHECK_ADDRS[idx_n*REG_AW +: REG_AW] : '0;
      if (accept) begin
        done            <= 1'b0;
        pass            <= 1'b0;
        fail_count      <= '0;
        first_fail_idx  <= '0;
        first_fail_data <= '0;
      end else begin
        if (state == CMP && mismatch) begin
          if (fail_count != 5'd31) fail_count <= fail_count + 5'd1;
          if (fail_count == 5'd0) begin
            first_fail_idx  <= idx;
            first_fail_data <= dbg_rdata;
          end
        end
        if (state == DONE) begin
          done <= 1'b1;
          pass <= (fail_count == 5'd0);
        end
      end
    end
  end

endmodule

// File: doc/instr_selftest.md
INSTR_SELFTEST -- requirements
Module: instr_selftest

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, register data width.
- REG_AW, 5, register address width.
- NUM_CHECKS, 4, number of register checks; legal range 1..16.
- RST_CYCLES, 1, DUT reset pulse length in cycles; minimum 1.
- WAIT_CYCLES, 7, cycles between DUT reset release and the first read; 0 allowed.
- CHECK_ADDRS, 0, packed NUM_CHECKS*REG_AW vector; entry i occupies bits [i*REG_AW +: REG_AW].
- CHECK_VALUES, 0, packed NUM_CHECKS*XLEN vector; entry i occupies bits [i*XLEN +: XLEN].
- STOP_ON_FAIL, 0, 1 = finish at the first mismatch; 0 = run all checks.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, one-cycle request to run a sequence.
- dut_reset, out, 1, active-high reset driven to the CPU/SoC under test.
- dbg_re, out, 1, debug read strobe to the register file.
- dbg_addr, out, REG_AW, debug read address.
- dbg_rdata, in, XLEN, register data; valid the cycle after dbg_re.
- busy, out, 1, sequence in progress.
- done, out, 1, sequence finished; held high until the next start.
- pass, out, 1, done and fail_count==0.
- fail_count, out, 5, number of mismatches in the current run.
- first_fail_idx, out, 4, index of the first mismatch.
- first_fail_data, out, XLEN, dbg_rdata captured at the first mismatch.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, RST_DUT, WAIT, READ, CMP and DONE.
REQ-004 A start sampled high in IDLE or DONE SHALL:
- move the FSM to RST_DUT;
- clear fail_count, first_fail_idx, first_fail_data, done and pass;
- set the check index to 0.
REQ-005 A start sampled high in any other state SHALL be ignored.
REQ-006 In RST_DUT, dut_reset SHALL be 1 for exactly RST_CYCLES cycles; the FSM then moves to WAIT.
REQ-007 The FSM SHALL stay in WAIT for exactly WAIT_CYCLES cycles, then move to READ; when WAIT_CYCLES=0 it SHALL go from RST_DUT directly to READ.
REQ-008 In READ (one cycle), the block SHALL drive dbg_re=1 and dbg_addr=CHECK_ADDRS entry[idx]; outside READ, dbg_re SHALL be 0 and dbg_addr 0.
REQ-009 In CMP (one cycle), the block SHALL compare dbg_rdata with CHECK_VALUES entry[idx].
REQ-010 On a mismatch, fail_count SHALL increment, saturating at 31.
REQ-011 If fail_count was 0 before that mismatch, first_fail_idx SHALL be set to idx and first_fail_data to dbg_rdata.
REQ-012 After CMP, the FSM SHALL go to DONE if idx==NUM_CHECKS-1, or if STOP_ON_FAIL=1 and a mismatch occurred; otherwise idx SHALL increment and the FSM return to READ.
REQ-013 In DONE, done SHALL be 1 and pass SHALL be (fail_count==0); both SHALL be registered and hold until the next accepted start.
REQ-014 busy SHALL be 1 exactly in states RST_DUT, WAIT, READ and CMP.
REQ-015 Latency from the start-sampling edge to done high SHALL be RST_CYCLES+WAIT_CYCLES+2*N+1 cycles, where N is the number of checks executed.
REQ-016 A start coinciding with the final CMP cycle SHALL be ignored; that run SHALL complete normally.
REQ-017 All outputs except dut_reset SHALL be registered; dut_reset SHALL equal (state==RST_DUT) OR reset.

Reset
REQ-018 While reset=1, asynchronously:
- state SHALL be IDLE and idx 0;
- busy, done, pass, dbg_re SHALL be 0;
- dbg_addr, fail_count, first_fail_idx, first_fail_data SHALL be 0;
- dut_reset SHALL be 1.
REQ-019 Reset asserted mid-sequence SHALL abort the run with no partial results retained; after reset release, the block SHALL wait in IDLE for start.

Verification
Common configuration: NUM_CHECKS=2, CHECK_ADDRS={5,7} (entry0=7, entry1=5), CHECK_VALUES={0x0,0x2F} (entry0=0x2F, entry1=0x0), RST_CYCLES=1, WAIT_CYCLES=7, register-file model returns data one cycle after dbg_re.
REQ-020 All pass: x7=0x2F, x5=0, pulse start -> dut_reset high 1 cycle; dbg_re high for addr 7 then addr 5; done=1, pass=1, fail_count=0 exactly 13 cycles after start.
REQ-021 Single mismatch, STOP_ON_FAIL=0: x7=0x2E -> both registers read; done at 13 cycles, pass=0, fail_count=1, first_fail_idx=0, first_fail_data=0x2E.
REQ-022 Early stop, STOP_ON_FAIL=1: x7=0x2E -> dbg_re pulses once only; done at 11 cycles, fail_count=1.
REQ-023 Abort: reset asserted during WAIT -> all outputs at reset values, dut_reset=1 while reset is high; a later start runs the full 13-cycle sequence.
REQ-024 Start handling: start pulsed during READ -> ignored, result unchanged; start in DONE -> done/pass/fail_count cleared on the next cycle and the sequence reruns.
